spi_tx_serializer: RTL and testbench

//  Parametrised SPI transmit serializer. Latches a DATA_W-bit result word on a start

---
 rtl/spi_tx_serializer.sv | 153 +++++++++++++++
 tb/tb_spi_tx_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_serializer
//  Description : SPI transmit serializer. A DATA_W-bit word is latched when
//                start is accepted in IDLE and then shifted out on sdo. Each
//                rising edge of the slow, externally generated sclk moves the
//                frame on by one bit. sclk is sampled in the clk domain.
//                Optional even parity: define SPI_TX_PARITY_EN to append
//                ^data_in as an extra frame bit, sent through the TAIL state.
//  Parameters  : DATA_W    - payload width in bits (>= 2)
//                MSB_FIRST - 1: data_in[DATA_W-1] is sent first,
//                            0: data_in[0] is sent first
//  Ports       : clk     in  system clock, all logic on posedge
//                rst     in  asynchronous active-high reset
//                start   in  frame request, sampled only in IDLE
//                data_in in  word to send, latched on start acceptance
//                sclk    in  SPI bit clock (level); a rising edge advances one bit
//                sdo     out serial data out
//                ena     out high while sdo carries a valid frame bit
//                busy    out high from start acceptance until done
//                done    out one-clk pulse at the end of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sclk,
    output logic              sdo,
    output logic              ena,
    output logic              busy,
    output logic              done
);

    // Sized to hold DATA_W+1 so the count never wraps within a frame.
    localparam int              CNT_W        = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] c_FRAME_BITS = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

`ifdef SPI_TX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_sclk_q;
`ifdef SPI_TX_PARITY_EN
    logic              r_parity;
`endif

    logic              w_sclk_rise;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_shift_next;

    // One-cycle pulse per sclk rise; a held-high sclk yields a single edge.
    assign w_sclk_rise = sclk & ~r_sclk_q;

    // Outgoing bit is taken from the end selected by MSB_FIRST and the
    // register moves toward that end with zero fill.
    assign w_next_bit   = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
    assign w_shift_next = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0}
                                    : {1'b0, r_shift[DATA_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sclk_q  <= 1'b0;
`ifdef SPI_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
            sdo       <= 1'b0;
            ena       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_sclk_q <= sclk;
            done     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // An sclk edge coinciding with acceptance is deliberately
                    // not consumed: the first bit waits for the next edge.
                    if (start) begin
                        r_shift   <= data_in;
                        r_bit_cnt <= '0;
`ifdef SPI_TX_PARITY_EN
                        r_parity  <= ^data_in;
`endif
                        busy      <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (w_sclk_rise) begin
                        if (r_bit_cnt < c_FRAME_BITS) begin
                            sdo       <= w_next_bit;
                            ena       <= 1'b1;
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                        end else begin
`ifdef SPI_TX_PARITY_EN
                            sdo     <= r_parity;
                            ena     <= 1'b1;
                            r_state <= ST_TAIL;
`else
                            sdo     <= 1'b0;
                            ena     <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_IDLE;
`endif
                        end
                    end
                end

`ifdef SPI_TX_PARITY_EN
                ST_TAIL: begin
                    if (w_sclk_rise) begin
                        sdo     <= 1'b0;
                        ena     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_tx_serializer
//  Description : Self-checking bench for spi_tx_serializer. Three instances
//                (8-bit MSB first, 8-bit LSB first, 12-bit MSB first) share
//                start/sclk/rst and are compared every cycle against a
//                frame-level reference model, plus literal bit sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_tx_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sclk = 1'b0;
    logic [7:0]  data8 = 8'h00;
    logic [11:0] data12 = 12'h000;

    logic [2:0]  sdo_v, ena_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;

`ifdef SPI_TX_PARITY_EN
    localparam bit c_PAR = 1'b1;
`else
    localparam bit c_PAR = 1'b0;
`endif

    always #5 clk = ~clk;

    spi_tx_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .data_in(data8), .sclk(sclk),
        .sdo(sdo_v[0]), .ena(ena_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    spi_tx_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .data_in(data8), .sclk(sclk),
        .sdo(sdo_v[1]), .ena(ena_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    spi_tx_serializer #(.DATA_W(12), .MSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .data_in(data12), .sclk(sclk),
        .sdo(sdo_v[2]), .ena(ena_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a frame is a list of bits; each sclk rise after
    // acceptance exposes the next list entry, the rise after the last one
    // ends the frame with a done pulse.
    // ------------------------------------------------------------------
    logic       m_q;
    logic       m_act [3];
    int         m_k   [3];
    int         m_n   [3];
    logic       m_bits [3][13];
    logic [2:0] e_sdo, e_ena, e_busy, e_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    = 1'b0;
            e_sdo  = '0;
            e_ena  = '0;
            e_busy = '0;
            e_done = '0;
            for (int i = 0; i < 3; i++) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
                m_n[i]   = 0;
            end
        end else begin
            logic rise;
            rise = sclk & ~m_q;
            m_q  = sclk;
            for (int i = 0; i < 3; i++) begin
                e_done[i] = 1'b0;
                if (!m_act[i]) begin
                    if (start) begin
                        logic [11:0] word;
                        int          w;
                        bit          msb;
                        word = (i == 2) ? data12 : {4'h0, data8};
                        w    = (i == 2) ? 12 : 8;
                        msb  = (i != 1);
                        for (int j = 0; j < w; j++)
                            m_bits[i][j] = msb ? word[w-1-j] : word[j];
                        m_bits[i][w] = ^word;
                        m_n[i]    = c_PAR ? w + 1 : w;
                        m_k[i]    = 0;
                        m_act[i]  = 1'b1;
                        e_busy[i] = 1'b1;
                    end
                end else if (rise) begin
                    m_k[i]++;
                    if (m_k[i] <= m_n[i]) begin
                        e_sdo[i] = m_bits[i][m_k[i]-1];
                        e_ena[i] = 1'b1;
                    end else begin
                        e_sdo[i]  = 1'b0;
                        e_ena[i]  = 1'b0;
                        e_busy[i] = 1'b0;
                        e_done[i] = 1'b1;
                        m_act[i]  = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_sdo%0d", i),  32'(sdo_v[i]),  32'(e_sdo[i]));
                chk($sformatf("model_ena%0d", i),  32'(ena_v[i]),  32'(e_ena[i]));
                chk($sformatf("model_busy%0d", i), 32'(busy_v[i]), 32'(e_busy[i]));
                chk($sformatf("model_done%0d", i), 32'(done_v[i]), 32'(e_done[i]));
            end
        end
    end

    int dcnt [3] = '{0, 0, 0};
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (done_v[i] === 1'b1) dcnt[i]++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; every call starts and ends 1 time unit after posedge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi);
        sclk = 1'b1;
        step(hi);
        sclk = 1'b0;
        step(3);
    endtask

    task automatic do_start(input logic [7:0] d8, input logic [11:0] d12);
        data8  = d8;
        data12 = d12;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin : stim
        logic [7:0]  lit_c4_msb;
        logic [7:0]  lit_c4_lsb;
        logic [11:0] lit_abc;
        logic [7:0]  lit_01;
        logic [7:0]  lit_aa;
        int          d0;

        lit_c4_msb = 8'b1100_0100;      // 1,1,0,0,0,1,0,0
        lit_c4_lsb = 8'b0010_0011;      // 0,0,1,0,0,0,1,1
        lit_abc    = 12'b1010_1011_1100;
        lit_01     = 8'b0000_0001;      // 0,0,0,0,0,0,0,1
        lit_aa     = 8'b1010_1010;

        step(2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_sdo%0d", i),  32'(sdo_v[i]),  32'd0);
            chk($sformatf("rst_ena%0d", i),  32'(ena_v[i]),  32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("rst_done%0d", i), 32'(done_v[i]), 32'd0);
        end
        rst = 1'b0;
        step(2);

        // Frame C4 / ABC; pulse 3 holds sclk high for 20 clocks (one edge).
        do_start(8'hC4, 12'hABC);
        for (int k = 1; k <= 14; k++) begin
            pulse((k == 3) ? 20 : 2);
            if (k <= 8) begin
                chk($sformatf("c4_msb_bit%0d", k), 32'(sdo_v[0]), 32'(lit_c4_msb[8-k]));
                chk($sformatf("c4_lsb_bit%0d", k), 32'(sdo_v[1]), 32'(lit_c4_lsb[8-k]));
                chk($sformatf("c4_ena%0d", k),     32'(ena_v[0]), 32'd1);
            end
            if (k <= 12)
                chk($sformatf("abc_bit%0d", k), 32'(sdo_v[2]), 32'(lit_abc[12-k]));
            if (k == 9) begin
                chk("c4_k9_ena",  32'(ena_v[0]),  c_PAR ? 32'd1 : 32'd0);
                chk("c4_k9_sdo",  32'(sdo_v[0]),  c_PAR ? 32'd1 : 32'd0);
                chk("c4_k9_busy", 32'(busy_v[0]), c_PAR ? 32'd1 : 32'd0);
            end
            if (k == 13 && c_PAR)
                chk("abc_parity", 32'(sdo_v[2]), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("f1_idle_busy%0d", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("f1_done_cnt%0d", i),  32'(dcnt[i]),   32'd1);
        end

        // Reset in the middle of an all-ones frame, then a fresh frame.
        do_start(8'hFF, 12'hFFF);
        pulse(2); pulse(2); pulse(2);
        d0 = dcnt[0];
        rst = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_sdo%0d", i),  32'(sdo_v[i]),  32'd0);
            chk($sformatf("midrst_ena%0d", i),  32'(ena_v[i]),  32'd0);
            chk($sformatf("midrst_busy%0d", i), 32'(busy_v[i]), 32'd0);
        end
        step(1);
        rst = 1'b0;
        step(3);
        chk("midrst_no_done", 32'(dcnt[0]), 32'(d0));
        do_start(8'h01, 12'h001);
        for (int k = 1; k <= 14; k++) begin
            pulse(2);
            if (k <= 8)
                chk($sformatf("w01_bit%0d", k), 32'(sdo_v[0]), 32'(lit_01[8-k]));
        end
        chk("w01_busy_end", 32'(busy_v[0]), 32'd0);

        // Start during a frame is ignored; held start chains frames.
        do_start(8'hAA, 12'h5A5);
        pulse(2); pulse(2);
        do_start(8'h00, 12'h000);
        for (int k = 3; k <= 8; k++) begin
            pulse(2);
            chk($sformatf("aa_bit%0d", k), 32'(sdo_v[0]), 32'(lit_aa[8-k]));
        end
        d0 = dcnt[0];
        data8  = 8'h55;
        data12 = 12'h3C3;
        start  = 1'b1;
        pulse(2); pulse(2);
        chk("chain_busy", 32'(busy_v[0]), 32'd1);
        chk("chain_done", 32'(dcnt[0]),   32'(d0 + 1));
        start = 1'b0;
        do_reset();

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) sclk = ~sclk;
            start  = ($urandom_range(0, 11) == 0);
            data8  = 8'($urandom);
            data12 = 12'($urandom);
            rst    = ($urandom_range(0, 999) == 0);
            step(1);
        end
        rst   = 1'b0;
        start = 1'b0;
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
